// File: rtl/fetch_sequencer.sv
// rtl/fetch_sequencer.sv - instruction-fetch controller with one-entry valid/ready output stage
//
// Owns the program counter, addresses a combinational program memory and
// registers each fetched word into a single output stage handed to the
// decoder over a valid/ready handshake.
//
// Ports:
//   clk, rst          clock and synchronous active-high reset
//   start             begin fetching at START_ADDR (IDLE/HALTED only)
//   stop              request halt (RUN only)
//   jump_valid        redirect request, jump_addr is the new pc
//   mem_pc            address to program memory (the pc register)
//   mem_instruction   combinational read data for mem_pc
//   instr_valid       output stage holds an instruction
//   instr_ready       decoder accepts the held instruction
//   instr_data        registered instruction word
//   instr_pc          address instr_data was fetched from
//   running, halted   state flags
//   fetch_count       number of completed transfers (wraps)
module fetch_sequencer #(
  parameter int INSTRUCTION_WIDTH = 40,
  parameter int PC_WIDTH          = 5,
  parameter int START_ADDR        = 0,
  parameter int END_ADDR          = 31,
  parameter int WRAP_EN           = 0,
  parameter int CNT_WIDTH         = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic                         stop,
  input  logic                         jump_valid,
  input  logic [PC_WIDTH-1:0]          jump_addr,
  output logic [PC_WIDTH-1:0]          mem_pc,
  input  logic [INSTRUCTION_WIDTH-1:0] mem_instruction,
  output logic                         instr_valid,
  input  logic                         instr_ready,
  output logic [INSTRUCTION_WIDTH-1:0] instr_data,
  output logic [PC_WIDTH-1:0]          instr_pc,
  output logic                         running,
  output logic                         halted,
  output logic [CNT_WIDTH-1:0]         fetch_count
);

  localparam logic [PC_WIDTH-1:0] START_PC = PC_WIDTH'(START_ADDR);
  localparam logic [PC_WIDTH-1:0] END_PC   = PC_WIDTH'(END_ADDR);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_HALTED} state_t;

  state_t                         state, state_next;
  logic [PC_WIDTH-1:0]            pc, pc_next;
  logic                           valid_next;
  logic [INSTRUCTION_WIDTH-1:0]   data_next;
  logic [PC_WIDTH-1:0]            ipc_next;
  logic                           transfer;
  logic                           count_en;

  assign mem_pc  = pc;
  assign running = (state == S_RUN);
  assign halted  = (state == S_HALTED);

  always_comb begin
    state_next = state;
    pc_next    = pc;
    valid_next = instr_valid;
    data_next  = instr_data;
    ipc_next   = instr_pc;
    transfer   = instr_valid & instr_ready;
    count_en   = transfer;

    // A transfer empties the stage unless a fetch below refills it.
    if (transfer) valid_next = 1'b0;

    case (state)
      S_IDLE, S_HALTED: begin
        if (start) begin
          state_next = S_RUN;
          pc_next    = START_PC;
        end
      end
      S_RUN: begin
        if (stop) begin
          state_next = S_DRAIN;
        end else if (jump_valid) begin
          // Flush: the held instruction is dropped and never counted.
          pc_next    = jump_addr;
          valid_next = 1'b0;
          count_en   = 1'b0;
        end else if (!instr_valid || instr_ready) begin
          valid_next = 1'b1;
          data_next  = mem_instruction;
          ipc_next   = pc;
          if (pc == END_PC) begin
            if (WRAP_EN != 0) pc_next = START_PC;
            else              state_next = S_DRAIN;
          end else begin
            pc_next = pc + PC_WIDTH'(1);
          end
        end
      end
      S_DRAIN: begin
        if (!instr_valid || transfer) state_next = S_HALTED;
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc          <= START_PC;
      instr_valid <= 1'b0;
      instr_data  <= '0;
      instr_pc    <= '0;
      fetch_count <= '0;
    end else begin
      pc          <= pc_next;
      instr_valid <= valid_next;
      instr_data  <= data_next;
      instr_pc    <= ipc_next;
      if (count_en) fetch_count <= fetch_count + CNT_WIDTH'(1);
    end
  end

endmodule

// File: tb/tb_fetch_sequencer.sv
// tb/tb_fetch_sequencer.sv - self-checking bench for fetch_sequencer (halt and wrap configurations)
module tb_fetch_sequencer;

  localparam int IW = 40;
  localparam int PW = 5;
  localparam int CW = 16;

  localparam int M_IDLE  = 0;
  localparam int M_RUN   = 1;
  localparam int M_DRAIN = 2;
  localparam int M_HALT  = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, start, stop, jump_valid, instr_ready;
  logic [PW-1:0] jump_addr;
  logic [IW-1:0] mem [32];

  logic [PW-1:0] mem_pc   [2];
  logic [IW-1:0] mem_ins  [2];
  logic          iv       [2];
  logic [IW-1:0] idata    [2];
  logic [PW-1:0] ipc      [2];
  logic          run_o    [2];
  logic          halt_o   [2];
  logic [CW-1:0] cnt      [2];

  assign mem_ins[0] = mem[mem_pc[0]];
  assign mem_ins[1] = mem[mem_pc[1]];

  // Instance 0: halts after address 3. Instance 1: wraps after address 31.
  fetch_sequencer #(.INSTRUCTION_WIDTH(IW), .PC_WIDTH(PW), .START_ADDR(0), .END_ADDR(3),
                    .WRAP_EN(0), .CNT_WIDTH(CW)) u0 (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .jump_valid(jump_valid),
    .jump_addr(jump_addr), .mem_pc(mem_pc[0]), .mem_instruction(mem_ins[0]),
    .instr_valid(iv[0]), .instr_ready(instr_ready), .instr_data(idata[0]),
    .instr_pc(ipc[0]), .running(run_o[0]), .halted(halt_o[0]), .fetch_count(cnt[0]));

  fetch_sequencer #(.INSTRUCTION_WIDTH(IW), .PC_WIDTH(PW), .START_ADDR(0), .END_ADDR(31),
                    .WRAP_EN(1), .CNT_WIDTH(CW)) u1 (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .jump_valid(jump_valid),
    .jump_addr(jump_addr), .mem_pc(mem_pc[1]), .mem_instruction(mem_ins[1]),
    .instr_valid(iv[1]), .instr_ready(instr_ready), .instr_data(idata[1]),
    .instr_pc(ipc[1]), .running(run_o[1]), .halted(halt_o[1]), .fetch_count(cnt[1]));

  // Reference model: mode, next address, held instruction and transfer count.
  int            m_st  [2];
  logic [PW-1:0] m_pc  [2];
  logic          m_v   [2];
  logic [IW-1:0] m_d   [2];
  logic [PW-1:0] m_ip  [2];
  logic [CW-1:0] m_cnt [2];

  function automatic logic [PW-1:0] last_addr(input int k);
    return (k == 0) ? 5'd3 : 5'd31;
  endfunction

  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      bit xfer;
      xfer = m_v[k] && instr_ready;
      if (rst) begin
        m_st[k] = M_IDLE; m_pc[k] = '0; m_v[k] = 1'b0;
        m_d[k] = '0; m_ip[k] = '0; m_cnt[k] = '0;
      end else if (m_st[k] == M_IDLE || m_st[k] == M_HALT) begin
        if (start) begin m_st[k] = M_RUN; m_pc[k] = '0; end
      end else if (m_st[k] == M_RUN) begin
        if (stop) begin
          if (xfer) begin m_cnt[k]++; m_v[k] = 1'b0; end
          m_st[k] = M_DRAIN;
        end else if (jump_valid) begin
          m_v[k] = 1'b0; m_pc[k] = jump_addr;
        end else if (xfer || !m_v[k]) begin
          if (xfer) m_cnt[k]++;
          m_d[k] = mem[m_pc[k]]; m_ip[k] = m_pc[k]; m_v[k] = 1'b1;
          if (m_pc[k] == last_addr(k)) begin
            if (k == 1) m_pc[k] = '0;
            else        m_st[k] = M_DRAIN;
          end else begin
            m_pc[k] = m_pc[k] + 5'd1;
          end
        end
      end else begin
        if (!m_v[k]) m_st[k] = M_HALT;
        else if (xfer) begin m_cnt[k]++; m_v[k] = 1'b0; m_st[k] = M_HALT; end
      end
    end
  end

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input int k, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s[u%0d] got=%0h expected=%0h at %0t", name, k, act, exp, $time);
    end
  endtask

  task automatic cmp_model();
    for (int k = 0; k < 2; k++) begin
      chk("mem_pc", k, 64'(mem_pc[k]), 64'(m_pc[k]));
      chk("instr_valid", k, 64'(iv[k]), 64'(m_v[k]));
      chk("instr_data", k, 64'(idata[k]), 64'(m_d[k]));
      chk("instr_pc", k, 64'(ipc[k]), 64'(m_ip[k]));
      chk("running", k, 64'(run_o[k]), 64'(m_st[k] == M_RUN));
      chk("halted", k, 64'(halt_o[k]), 64'(m_st[k] == M_HALT));
      chk("fetch_count", k, 64'(cnt[k]), 64'(m_cnt[k]));
    end
  endtask

  task automatic tick();
    @(negedge clk);
    cmp_model();
  endtask

  task automatic do_reset();
    #1 rst = 1'b1; start = 1'b0; stop = 1'b0; jump_valid = 1'b0;
    tick();
    #1 rst = 1'b0;
  endtask

  initial begin
    int n;
    logic [IW-1:0] pat;
    for (int i = 0; i < 32; i++) mem[i] = 40'hA000000000 | 40'(i);
    rst = 1'b1; start = 1'b0; stop = 1'b0; jump_valid = 1'b0;
    jump_addr = '0; instr_ready = 1'b0;
    tick(); tick();

    // Reset state
    chk("rst_valid", 0, 64'(iv[0]), 64'd0);
    chk("rst_mem_pc", 0, 64'(mem_pc[0]), 64'd0);
    chk("rst_count", 0, 64'(cnt[0]), 64'd0);
    chk("rst_running", 0, 64'(run_o[0]), 64'd0);
    chk("rst_halted", 0, 64'(halt_o[0]), 64'd0);

    // Straight-line program 0..3 then halt
    #1 rst = 1'b0; start = 1'b1; instr_ready = 1'b1;
    tick();
    #1 start = 1'b0;
    chk("run_running", 0, 64'(run_o[0]), 64'd1);
    chk("run_first_valid", 0, 64'(iv[0]), 64'd0);
    for (int i = 0; i < 4; i++) begin
      tick();
      pat = 40'hA000000000 | 40'(i);
      chk("seq_valid", 0, 64'(iv[0]), 64'd1);
      chk("seq_pc", 0, 64'(ipc[0]), 64'(i));
      chk("seq_data", 0, 64'(idata[0]), 64'(pat));
    end
    tick(); tick();
    chk("end_halted", 0, 64'(halt_o[0]), 64'd1);
    chk("end_count", 0, 64'(cnt[0]), 64'd4);

    // Backpressure stall at pc 1
    do_reset();
    start = 1'b1; instr_ready = 1'b1;
    tick();
    #1 start = 1'b0;
    tick(); tick();
    #1 instr_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall_pc", 0, 64'(ipc[0]), 64'd1);
      chk("stall_data", 0, 64'(idata[0]), 64'(40'hA000000001));
      chk("stall_mem_pc", 0, 64'(mem_pc[0]), 64'd2);
    end
    #1 instr_ready = 1'b1;
    tick();
    chk("stall_release_pc", 0, 64'(ipc[0]), 64'd2);
    chk("stall_release_count", 0, 64'(cnt[0]), 64'd2);

    // Jump to 17 while pc 4 is valid (wrap instance)
    do_reset();
    start = 1'b1; instr_ready = 1'b1;
    tick();
    #1 start = 1'b0;
    n = 0;
    while (!(iv[1] && ipc[1] == 5'd4) && n < 40) begin tick(); n++; end
    chk("jump_found_pc4", 1, 64'(n < 40), 64'd1);
    chk("jump_pre_count", 1, 64'(cnt[1]), 64'd4);
    #1 jump_valid = 1'b1; jump_addr = 5'd17;
    tick();
    #1 jump_valid = 1'b0;
    chk("jump_bubble", 1, 64'(iv[1]), 64'd0);
    chk("jump_flush_count", 1, 64'(cnt[1]), 64'd4);
    tick();
    chk("jump_target", 1, 64'(ipc[1]), 64'd17);
    chk("jump_target_valid", 1, 64'(iv[1]), 64'd1);
    tick();
    chk("jump_next", 1, 64'(ipc[1]), 64'd18);
    chk("jump_next_count", 1, 64'(cnt[1]), 64'd5);

    // Stop under backpressure, then restart
    do_reset();
    start = 1'b1; instr_ready = 1'b0;
    tick();
    #1 start = 1'b0;
    tick();
    #1 stop = 1'b1;
    tick();
    #1 stop = 1'b0;
    chk("stop_not_running", 0, 64'(run_o[0]), 64'd0);
    chk("stop_held_valid", 0, 64'(iv[0]), 64'd1);
    tick();
    chk("stop_mem_pc", 0, 64'(mem_pc[0]), 64'd1);
    #1 instr_ready = 1'b1;
    tick();
    chk("stop_halted", 0, 64'(halt_o[0]), 64'd1);
    chk("stop_count", 0, 64'(cnt[0]), 64'd1);
    #1 start = 1'b1;
    tick();
    #1 start = 1'b0;
    tick();
    chk("restart_pc", 0, 64'(ipc[0]), 64'd0);
    chk("restart_valid", 0, 64'(iv[0]), 64'd1);

    // Wrap 30,31,0,1
    do_reset();
    start = 1'b1; instr_ready = 1'b1;
    tick();
    #1 start = 1'b0;
    n = 0;
    while (!(iv[1] && ipc[1] == 5'd30) && n < 60) begin tick(); n++; end
    chk("wrap_found_30", 1, 64'(n < 60), 64'd1);
    tick(); chk("wrap_31", 1, 64'(ipc[1]), 64'd31);
    tick(); chk("wrap_0", 1, 64'(ipc[1]), 64'd0);
    tick(); chk("wrap_1", 1, 64'(ipc[1]), 64'd1);
    chk("wrap_running", 1, 64'(run_o[1]), 64'd1);

    // Reset mid-run
    #1 rst = 1'b1;
    tick();
    #1 rst = 1'b0;
    chk("midrst_valid", 1, 64'(iv[1]), 64'd0);
    chk("midrst_data", 1, 64'(idata[1]), 64'd0);
    chk("midrst_pc", 1, 64'(ipc[1]), 64'd0);
    chk("midrst_count", 1, 64'(cnt[1]), 64'd0);
    chk("midrst_running", 1, 64'(run_o[1]), 64'd0);
    tick(); tick();
    chk("midrst_idle_valid", 1, 64'(iv[1]), 64'd0);
    chk("midrst_idle_running", 1, 64'(run_o[1]), 64'd0);

    // Random traffic against the model
    for (int c = 0; c < 4000; c++) begin
      #1;
      rst         = ($urandom % 300) == 0;
      start       = ($urandom % 10) == 0;
      stop        = ($urandom % 25) == 0;
      jump_valid  = ($urandom % 15) == 0;
      jump_addr   = PW'($urandom);
      instr_ready = ($urandom % 4) != 0;
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
Instruction-fetch controller that sequences the program memory (combinational ROM indexed by PC, INSTRUCTION_WIDTH-bit words). It owns the program counter, drives the memory address, and registers each fetched word into a one-entry output stage. The output stage talks to the decoder through a valid/ready handshake. It supports start, stop, jump redirect, backpressure stalls, and end-of-program halt or wrap.

Parameters:
INSTRUCTION_WIDTH, 40, instruction word width
PC_WIDTH, 5, program counter / memory address width
START_ADDR, 0, first fetch address after start
END_ADDR, 31, last program address
WRAP_EN, 0, 1: wrap to START_ADDR after END_ADDR; 0: halt after END_ADDR
CNT_WIDTH, 16, delivered-instruction counter width

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  synchronous, active-high reset
start  input  1  begin fetching at START_ADDR (honoured in IDLE/HALTED only)
stop  input  1  request halt (honoured in RUN only)
jump_valid  input  1  redirect request
jump_addr  input  PC_WIDTH  redirect target
mem_pc  output  PC_WIDTH  address to program memory
mem_instruction  input  INSTRUCTION_WIDTH  memory read data, combinational from mem_pc
instr_valid  output  1  output stage holds an instruction
instr_ready  input  1  decoder accepts
instr_data  output  INSTRUCTION_WIDTH  registered instruction
instr_pc  output  PC_WIDTH  address instr_data came from
running  output  1  state==RUN
halted  output  1  state==HALTED
fetch_count  output  CNT_WIDTH  count of completed transfers

Behaviour:
- States: IDLE, RUN, DRAIN, HALTED.
- Reset values: state=IDLE, pc=START_ADDR, instr_valid=0, instr_data=0, instr_pc=0, fetch_count=0. Reset mid-operation discards any pending instruction.
- mem_pc = pc register, driven combinationally with no added delay.
- Transfer = instr_valid & instr_ready. On every transfer, fetch_count increments and wraps at 2^CNT_WIDTH. The counter is cleared only by rst.
- Fetch occurs in a cycle when: state==RUN, no stop, no jump, and (instr_valid==0 or instr_ready==1).
  - On fetch: instr_data<=mem_instruction, instr_pc<=pc, instr_valid<=1.
  - Next pc: pc+1 (mod 2^PC_WIDTH). When pc==END_ADDR, next pc is START_ADDR if WRAP_EN=1; otherwise pc is held and state<=DRAIN.
- Throughput: one instruction per cycle while instr_ready=1. Fetch-to-valid latency is one cycle.
- Stall: instr_valid=1 & instr_ready=0 holds instr_data, instr_pc, and pc stable. No fetch occurs.
- If a transfer occurs with no fetch in the same cycle, instr_valid<=0.
- Priority, from highest: rst > stop > jump_valid > fetch.
- IDLE:
  - start -> RUN with pc<=START_ADDR.
  - stop and jump are ignored.
- RUN:
  - stop -> DRAIN. No fetch in that cycle or afterwards.
  - jump_valid (without stop) -> pc<=jump_addr and instr_valid<=0. The pending instruction is flushed and not counted, even if instr_ready=1. No fetch in that cycle. If jump_valid is asserted in cycle N, the instruction from jump_addr is valid in cycle N+2.
  - start is ignored.
- DRAIN:
  - No fetches. The pending instruction remains until transferred.
  - Goes to HALTED at the end of a cycle in which instr_valid==0 or a transfer occurs.
  - start, stop, and jump are ignored.
- HALTED:
  - instr_valid=0.
  - start -> RUN with pc<=START_ADDR.
- start and stop asserted together in IDLE/HALTED: start wins, since stop is ignored there.

Test Plan:
- Reset, start pulse, instr_ready=1, memory[i]=40'hA000000000|i, WRAP_EN=0, END_ADDR=3 -> instr_valid cycles 2..5 with instr_pc 0,1,2,3 and data A0..00 through A0..03. Then DRAIN, then halted=1, fetch_count=4.
- Hold instr_ready=0 for 3 cycles while valid at pc=1 -> instr_data/instr_pc frozen at pc 1, mem_pc stays 2. Release -> pc 2 delivered the next cycle, no duplicates or skips.
- jump_valid with jump_addr=17 while valid at pc=4 and instr_ready=1 -> pc 4 not counted, instr_valid=0 for one cycle, then instr_pc=17 followed by 18.
- stop while instr_valid=1 and instr_ready=0 -> no new fetches; after instr_ready goes high, one transfer, then halted=1. A later start resumes at START_ADDR.
- WRAP_EN=1, END_ADDR=31, continuous ready -> instr_pc sequence 30,31,0,1; running stays 1.
- rst asserted mid-RUN with instr_valid=1 -> next cycle all outputs are at reset values and state=IDLE; start is required to resume.
